// File: rtl/obi_to_wishbone_bridge.sv
// OBI-to-Wishbone bridge: one outstanding OBI request is carried as a
// single Wishbone classic cycle, with one OBI response per grant.
// Optional build macro OBI_WB_TIMEOUT_EN adds a bus watchdog that aborts a
// Wishbone cycle with an error after TIMEOUT_CYCLES cycles without ack/err.
module obi_to_wishbone_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // OBI slave side
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  // Wishbone master side
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // The watchdog needs at least two cycles to make sense.
  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        in_bus;
  logic        tmo_hit;

  assign in_bus = (state_q == StBus);

`ifdef OBI_WB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside BUS so it starts from zero on every entry.
  always_comb begin
    cnt_d = '0;
    if (in_bus) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign tmo_hit = in_bus && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Grant only when no Wishbone cycle is in flight.
  assign obi_gnt_o = obi_req_i && (state_q != StBus);

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (obi_gnt_o) begin
          state_d = StBus;
          adr_d   = obi_addr_i;
          we_d    = obi_we_i;
          sel_d   = obi_be_i;
          wdat_d  = obi_wdata_i;
        end else begin
          state_d = StIdle;
        end
      end
      StBus: begin
        // Error wins over a simultaneous ack.
        if (wb_err_i || tmo_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (wb_ack_i) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : wb_dat_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign wb_cyc_o     = in_bus;
  assign wb_stb_o     = in_bus;
  assign wb_we_o      = in_bus & we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = wdat_q;
  assign obi_rvalid_o = (state_q == StResp);
  assign obi_rdata_o  = obi_rvalid_o ? rdata_q : 32'h0;
  assign obi_err_o    = obi_rvalid_o & err_q;

endmodule

// File: tb/tb_obi_to_wishbone_bridge.sv
// Directed self-checking bench for obi_to_wishbone_bridge.
module tb_obi_to_wishbone_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters sampled on the falling edge.
  int rv_cnt = 0;
  int gnt_cnt = 0;
  int cyc_cnt = 0;
  int gnt_in_bus = 0;

  obi_to_wishbone_bridge #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (obi_rvalid_o) rv_cnt++;
      if (obi_gnt_o) gnt_cnt++;
      if (wb_cyc_o) cyc_cnt++;
      if (obi_gnt_o && wb_cyc_o) gnt_in_bus++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int base_rv;
    int base_cyc;
    int base_gnt;
    int n;

    rst_n = 1'b0;
    obi_req_i = 1'b0;
    obi_addr_i = '0;
    obi_we_i = 1'b0;
    obi_be_i = '0;
    obi_wdata_i = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_we", {31'h0, wb_we_o}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_rvalid", {31'h0, obi_rvalid_o}, 32'h0);
    chk("rst_rdata", obi_rdata_o, 32'h0);

    // Read, ack in the third cycle of cyc.
    base_rv = rv_cnt;
    base_cyc = cyc_cnt;
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_1000;
    obi_we_i = 1'b0;
    obi_be_i = 4'hF;
    #1;
    chk("rd_gnt_idle", {31'h0, obi_gnt_o}, 32'h1);
    tick();
    obi_req_i = 1'b0;
    chk("rd_cyc", {31'h0, wb_cyc_o}, 32'h1);
    chk("rd_adr", wb_adr_o, 32'h0000_1000);
    chk("rd_we", {31'h0, wb_we_o}, 32'h0);
    tick();
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 1'b0;
    chk("rd_rvalid", {31'h0, obi_rvalid_o}, 32'h1);
    chk("rd_rdata", obi_rdata_o, 32'hCAFE_F00D);
    chk("rd_err", {31'h0, obi_err_o}, 32'h0);
    chk("rd_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
    tick();
    chk("rd_rvalid_once", {31'h0, obi_rvalid_o}, 32'h0);
    chk("rd_rv_count", rv_cnt - base_rv, 32'd1);
    chk("rd_cyc_len", cyc_cnt - base_cyc, 32'd3);

    // Write, immediate ack; wb_dat_i left non-zero.
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_2004;
    obi_we_i = 1'b1;
    obi_be_i = 4'h3;
    obi_wdata_i = 32'h1234_5678;
    tick();
    obi_req_i = 1'b0;
    obi_we_i = 1'b0;
    wb_ack_i = 1'b1;
    chk("wr_sel", {28'h0, wb_sel_o}, 32'h3);
    chk("wr_we", {31'h0, wb_we_o}, 32'h1);
    chk("wr_dat", wb_dat_o, 32'h1234_5678);
    chk("wr_adr", wb_adr_o, 32'h0000_2004);
    tick();
    wb_ack_i = 1'b0;
    chk("wr_rvalid", {31'h0, obi_rvalid_o}, 32'h1);
    chk("wr_rdata", obi_rdata_o, 32'h0);
    chk("wr_err", {31'h0, obi_err_o}, 32'h0);
    chk("wr_we_idle", {31'h0, wb_we_o}, 32'h0);
    tick();

    // Four back-to-back reads with request held.
    base_rv = rv_cnt;
    base_gnt = gnt_cnt;
    gnt_in_bus = gnt_in_bus;
    n = gnt_in_bus;
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_3000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("b2b_gnt", {31'h0, obi_gnt_o}, 32'h1);
      tick();
      chk("b2b_adr", wb_adr_o, 32'h0000_3000 + 32'(4 * k));
      chk("b2b_no_gnt_bus", {31'h0, obi_gnt_o}, 32'h0);
      obi_addr_i = 32'h0000_3000 + 32'(4 * (k + 1));
      wb_dat_i = 32'hA000_0000 + 32'(k);
      wb_ack_i = 1'b1;
      if (k == 3) obi_req_i = 1'b0;
      tick();
      wb_ack_i = 1'b0;
      chk("b2b_rvalid", {31'h0, obi_rvalid_o}, 32'h1);
      chk("b2b_rdata", obi_rdata_o, 32'hA000_0000 + 32'(k));
    end
    tick();
    chk("b2b_idle", {31'h0, obi_rvalid_o}, 32'h0);
    chk("b2b_gnts", gnt_cnt - base_gnt, 32'd4);
    chk("b2b_rvs", rv_cnt - base_rv, 32'd4);
    chk("b2b_gnt_in_bus", gnt_in_bus - n, 32'd0);

    // Ack and error together count as error.
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_4000;
    tick();
    obi_req_i = 1'b0;
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("ae_rvalid", {31'h0, obi_rvalid_o}, 32'h1);
    chk("ae_err", {31'h0, obi_err_o}, 32'h1);
    chk("ae_rdata", obi_rdata_o, 32'h0);
    tick();

    // Reset mid-BUS, then a late ack.
    base_rv = rv_cnt;
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_5000;
    obi_be_i = 4'hC;
    tick();
    obi_req_i = 1'b0;
    tick();
    chk("rb_cyc_before", {31'h0, wb_cyc_o}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rb_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("rb_rvalid", {31'h0, obi_rvalid_o}, 32'h0);
    chk("rb_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rb_adr", wb_adr_o, 32'h0);
    chk("rb_sel", {28'h0, wb_sel_o}, 32'h0);
    chk("rb_rdata", obi_rdata_o, 32'h0);
    tick();
    chk("rb_rv_count", rv_cnt - base_rv, 32'd0);

    // Slave never answers.
    obi_req_i = 1'b1;
    obi_addr_i = 32'h0000_6000;
    wb_dat_i = 32'h5555_AAAA;
    tick();
    obi_req_i = 1'b0;
`ifdef OBI_WB_TIMEOUT_EN
    n = 0;
    while (wb_cyc_o && n < 40) begin
      n++;
      tick();
    end
    chk("to_cyc_len", n, 32'd16);
    chk("to_rvalid", {31'h0, obi_rvalid_o}, 32'h1);
    chk("to_err", {31'h0, obi_err_o}, 32'h1);
    chk("to_rdata", obi_rdata_o, 32'h0);
`else
    base_rv = rv_cnt;
    repeat (1000) tick();
    chk("nto_cyc", {31'h0, wb_cyc_o}, 32'h1);
    chk("nto_rvs", rv_cnt - base_rv, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
